// File: rtl/dmem_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_if : memory-stage bus between pipeline and data-memory responder
// Rev 1.0
// ----------------------------------------------------------------------------
interface dmem_if;
  logic        memwrite;
  logic        memread;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        memstall;
  logic        misalign;

  modport master (
    output memwrite, memread, dataadr, writedata,
    input  readdata, memstall, misalign
  );

  modport slave (
    input  memwrite, memread, dataadr, writedata,
    output readdata, memstall, misalign
  );
endinterface
`default_nettype wire

// File: rtl/dmem_latency_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_latency_responder : data memory serving loads/stores after LATENCY
// stall cycles, holding the pipeline via memstall.   Rev 1.0
// ----------------------------------------------------------------------------
module dmem_latency_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  wire logic clk,
  input  wire logic reset,
  dmem_if.slave     bus
);

  localparam int         c_aw       = $clog2(DEPTH);
  localparam logic [3:0] c_cnt_load = 4'(LATENCY - 1);
  localparam bit         c_single   = (LATENCY == 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_wait = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_dec;
  logic [c_aw-1:0] r_idx;
  logic [31:0]     r_wdata;
  logic            r_is_store;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH];

  logic            w_access;
  logic            w_aligned;
  logic            w_req;
  logic [c_aw-1:0] w_idx;
  logic            w_unused;

  logic            w_stall;
  logic            w_misalign;
  logic            w_accept;
  logic            w_commit_store;
  logic            w_commit_load;

  assign w_access  = bus.memwrite | bus.memread;
  assign w_aligned = (bus.dataadr[1:0] == 2'b00);
  assign w_req     = w_access & w_aligned;
  // Upper address bits alias onto the same word.
  assign w_idx     = bus.dataadr[c_aw+1:2];
  assign w_unused  = ^bus.dataadr[31:c_aw+2];
  assign w_cnt_dec = r_cnt - 4'd1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_idle;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (w_req) w_next = c_single ? c_done : c_wait;
      c_wait:  if (w_cnt_dec == 4'd0) w_next = c_done;
      c_done:  w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  // Reset gates every output so an aborted access never stalls or commits.
  always_comb begin
    w_stall        = 1'b0;
    w_misalign     = 1'b0;
    w_accept       = 1'b0;
    w_commit_store = 1'b0;
    w_commit_load  = 1'b0;
    if (!reset) begin
      case (r_state)
        c_idle: begin
          w_accept   = w_req;
          w_stall    = w_req;
          w_misalign = w_access & ~w_aligned;
        end
        c_wait:  w_stall = 1'b1;
        c_done: begin
          w_commit_store = r_is_store;
          w_commit_load  = ~r_is_store;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= 4'd0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_is_store <= 1'b0;
      r_rdata    <= 32'd0;
    end else begin
      if (w_accept) begin
        r_cnt      <= c_cnt_load;
        r_idx      <= w_idx;
        r_wdata    <= bus.writedata;
        r_is_store <= bus.memwrite;
      end else if (r_state == c_wait) begin
        r_cnt <= w_cnt_dec;
      end
      if (w_commit_load) r_rdata <= r_mem[r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit_store) r_mem[r_idx] <= r_wdata;
  end

  assign bus.readdata = r_rdata;
  assign bus.memstall = w_stall;
  assign bus.misalign = w_misalign;

endmodule
`default_nettype wire

// File: tb/tb_dmem_latency_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmem_latency_responder : directed table plus randomized accesses on
// LATENCY 2 / 1 / 15 instances against an array-based memory model.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_dmem_latency_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  mw = '0, mr = '0, st, mis;
  logic [31:0] adr [3];
  logic [31:0] wd  [3];
  logic [31:0] rd  [3];

  dmem_if bus0();
  dmem_if bus1();
  dmem_if bus2();

  assign bus0.memwrite = mw[0]; assign bus0.memread = mr[0];
  assign bus0.dataadr = adr[0]; assign bus0.writedata = wd[0];
  assign bus1.memwrite = mw[1]; assign bus1.memread = mr[1];
  assign bus1.dataadr = adr[1]; assign bus1.writedata = wd[1];
  assign bus2.memwrite = mw[2]; assign bus2.memread = mr[2];
  assign bus2.dataadr = adr[2]; assign bus2.writedata = wd[2];
  assign st  = {bus2.memstall, bus1.memstall, bus0.memstall};
  assign mis = {bus2.misalign, bus1.misalign, bus0.misalign};
  assign rd[0] = bus0.readdata;
  assign rd[1] = bus1.readdata;
  assign rd[2] = bus2.readdata;

  dmem_latency_responder #(.DEPTH(64), .LATENCY(2))  u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  dmem_latency_responder #(.DEPTH(64), .LATENCY(1))  u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  dmem_latency_responder #(.DEPTH(64), .LATENCY(15)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int lat [3] = '{2, 1, 15};

  // Reference: word store per instance, validity flags, last load value.
  logic [31:0] mdl [3][64];
  bit          vld [3][64];
  logic [31:0] exp_rd [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          s;
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] d;
    int          est;
    bit          emis;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Presents a request, holds it while stalled, releases after the DONE edge.
  task automatic access(input int s, input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, output int n, output bit m0,
                        output logic [31:0] rdv);
    int c = 0;
    n = 0;
    mw[s] = w; mr[s] = r; adr[s] = a; wd[s] = d;
    #1;
    m0 = mis[s];
    while (st[s] && c < 40) begin
      n++; c++;
      @(negedge clk); #1;
    end
    if (c >= 40) begin
      checks++; errors++;
      $display("FAIL stall_timeout: got %0d stalled cycles expected %0d", c, lat[s]);
    end
    @(negedge clk);
    mw[s] = 1'b0; mr[s] = 1'b0;
    #1;
    rdv = rd[s];
  endtask

  task automatic model_apply(input int s, input bit w, input bit r, input logic [31:0] a,
                             input logic [31:0] d, output int est, output bit emis);
    int idx;
    idx  = int'(a >> 2) % 64;
    est  = 0;
    emis = 1'b0;
    if (w || r) begin
      if (a[1:0] != 2'b00) emis = 1'b1;
      else begin
        est = lat[s];
        if (w) begin mdl[s][idx] = d; vld[s][idx] = 1'b1; end
        else exp_rd[s] = mdl[s][idx];
      end
    end
  endtask

  task automatic run_vec(input int i);
    int n, est; bit m, emis; logic [31:0] rv;
    access(tbl[i].s, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, n, m, rv);
    model_apply(tbl[i].s, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, est, emis);
    check($sformatf("vec%0d_stall", i), n, tbl[i].est);
    check($sformatf("vec%0d_misalign", i), {31'd0, m}, {31'd0, tbl[i].emis});
    check($sformatf("vec%0d_readdata", i), rv, tbl[i].erd);
  endtask

  initial begin
    int n, est; bit m, emis; logic [31:0] rv;
    bit w, r; int s; logic [31:0] a, d; int idx;

    tbl[0]  = '{0, 1, 0, 84,  7,  2, 0, 0};
    tbl[1]  = '{0, 0, 1, 84,  0,  2, 0, 7};
    tbl[2]  = '{0, 1, 0, 80,  5,  2, 0, 7};
    tbl[3]  = '{0, 1, 0, 84,  7,  2, 0, 7};
    tbl[4]  = '{0, 0, 1, 80,  0,  2, 0, 5};
    tbl[5]  = '{0, 0, 1, 84,  0,  2, 0, 7};
    tbl[6]  = '{0, 1, 0, 82,  99, 0, 1, 7};
    tbl[7]  = '{0, 0, 1, 80,  0,  2, 0, 5};
    tbl[8]  = '{0, 1, 1, 84,  3,  2, 0, 7};
    tbl[9]  = '{0, 0, 1, 340, 0,  2, 0, 3};
    tbl[10] = '{1, 1, 0, 8,   32'hdeadbeef, 1, 0, 0};
    tbl[11] = '{1, 0, 1, 8,   0,  1, 0, 32'hdeadbeef};
    tbl[12] = '{2, 1, 0, 12,  32'h12345678, 15, 0, 0};
    tbl[13] = '{2, 0, 1, 12,  0,  15, 0, 32'h12345678};
    tbl[14] = '{1, 0, 1, 264, 0,  1, 0, 32'hdeadbeef};
    tbl[15] = '{1, 0, 1, 6,   0,  0, 1, 32'hdeadbeef};

    for (int k = 0; k < 3; k++) begin
      exp_rd[k] = 32'd0;
      for (int j = 0; j < 64; j++) vld[k][j] = 1'b0;
    end

    // Reset with an aligned request pending: nothing may stall or pulse.
    for (int k = 0; k < 3; k++) begin adr[k] = 32'd84; wd[k] = 32'd1; end
    mw = 3'b111;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_stall%0d", k), {31'd0, st[k]}, 32'd0);
      check($sformatf("rst_misalign%0d", k), {31'd0, mis[k]}, 32'd0);
      check($sformatf("rst_readdata%0d", k), rd[k], 32'd0);
    end
    @(negedge clk);
    mw = 3'b000;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Store 9 @84 aborted by reset while in WAIT.
    mw[0] = 1'b1; adr[0] = 32'd84; wd[0] = 32'd9;
    #1;
    check("abort_stall_c0", {31'd0, st[0]}, 32'd1);
    @(negedge clk); #1;
    check("abort_stall_wait", {31'd0, st[0]}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_stall_reset", {31'd0, st[0]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mw[0] = 1'b0;
    for (int k = 0; k < 3; k++) exp_rd[k] = 32'd0;
    #1;
    check("abort_readdata_cleared", rd[0], 32'd0);
    check("abort_idle_stall", {31'd0, st[0]}, 32'd0);
    access(0, 1'b0, 1'b1, 32'd84, 32'd0, n, m, rv);
    model_apply(0, 1'b0, 1'b1, 32'd84, 32'd0, est, emis);
    check("abort_load84", rv, 32'd7);

    for (int i = 8; i < 16; i++) run_vec(i);

    // Randomized traffic against the model.
    for (int t = 0; t < 300; t++) begin
      s   = $urandom_range(0, 2);
      idx = $urandom_range(0, 15);
      a   = 32'(idx * 4 + $urandom_range(0, 3) * 256);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      d   = $urandom;
      w   = $urandom_range(0, 1) == 1;
      r   = !w || ($urandom_range(0, 7) == 0);
      if (!w && !vld[s][idx]) w = 1'b1;
      access(s, w, r, a, d, n, m, rv);
      model_apply(s, w, r, a, d, est, emis);
      check($sformatf("rnd%0d_stall", t), n, est);
      check($sformatf("rnd%0d_misalign", t), {31'd0, m}, {31'd0, emis});
      check($sformatf("rnd%0d_readdata", t), rv, exp_rd[s]);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
